// File: rtl/err_compute.sv
// err_compute: producer of the err_sat/err_vld error term for the PID blocks.
// Periodically powers the IR emitters and lets them settle. It then runs six
// A2D conversions (inner, middle and outer sensors, right and left) and
// accumulates a weighted right-minus-left sum. The sum is saturated to 11-bit
// signed and presented with a one-cycle err_vld strobe.
// Optional build macro ERR_AVG_EN: err_sat becomes the average of the current
// and previous saturated results.
module err_compute #(
  parameter int PERIOD_CYC = 4096,
  parameter int SETTLE_CYC = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        IR_en,
  output logic [10:0] err_sat,
  output logic        err_vld
);

  localparam int PW = $clog2(PERIOD_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      per_cnt;
  logic               tick;
  logic [SW-1:0]      settle_cnt;
  logic [2:0]         idx;
  logic signed [15:0] acc;
  logic signed [10:0] sat_now;

  // Sequence table: A2D channel visited at each index.
  function automatic logic [2:0] chan_of(input logic [2:0] i);
    case (i)
      3'd0:    chan_of = 3'd1;
      3'd1:    chan_of = 3'd0;
      3'd2:    chan_of = 3'd4;
      3'd3:    chan_of = 3'd2;
      3'd4:    chan_of = 3'd3;
      default: chan_of = 3'd7;
    endcase
  endfunction

  // Signed, weighted contribution of one conversion: right sensors add,
  // left sensors subtract; weight doubles from inner to middle to outer.
  function automatic logic signed [15:0] term_of(input logic [2:0] i,
                                                 input logic [11:0] r);
    logic signed [15:0] mag;
    mag = signed'({4'b0, r});
    case (i)
      3'd0:    term_of = mag;
      3'd1:    term_of = -mag;
      3'd2:    term_of = mag <<< 1;
      3'd3:    term_of = -(mag <<< 1);
      3'd4:    term_of = mag <<< 2;
      default: term_of = -(mag <<< 2);
    endcase
  endfunction

  // Clamp the 16-bit accumulator into the 11-bit signed output range.
  function automatic logic signed [10:0] sat11(input logic signed [15:0] a);
    if (a > 16'sd1023)
      sat11 = 11'sh3FF;
    else if (a < -16'sd1024)
      sat11 = 11'sh400;
    else
      sat11 = a[10:0];
  endfunction

  assign tick    = en && (per_cnt == PER_LAST);
  assign sat_now = sat11(acc);

  // Period counter: free-runs while enabled, wraps on tick, held at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      per_cnt <= '0;
    else if (!en || tick)
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SETTLE;
      SETTLE:  if (settle_cnt == SET_LAST) state_d = CONV;
      CONV:    state_d = WAIT;
      WAIT:    if (cnv_cmplt) state_d = (idx == 3'd5) ? DONE : CONV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencing registers: emitter enable, channel select, start pulse, accumulator.
  // chnnl is loaded on entry to CONV so it is already stable when strt_cnv rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      idx        <= '0;
      acc        <= '0;
      IR_en      <= 1'b0;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
    end else begin
      strt_cnv <= (state_d == CONV);
      case (state_q)
        IDLE: begin
          if (tick) begin
            IR_en      <= 1'b1;
            acc        <= '0;
            idx        <= '0;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SET_LAST)
            chnnl <= chan_of(idx);
        end
        WAIT: begin
          if (cnv_cmplt) begin
            acc <= acc + term_of(idx, res);
            if (idx != 3'd5) begin
              idx   <= idx + 3'd1;
              chnnl <= chan_of(idx + 3'd1);
            end
          end
        end
        DONE:    IR_en <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ERR_AVG_EN
  logic signed [10:0] prev_sat;
  logic signed [11:0] avg_sum;

  assign avg_sum = {sat_now[10], sat_now} + {prev_sat[10], prev_sat};

  // Output register: average of this and the previous saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat  <= '0;
      err_vld  <= 1'b0;
      prev_sat <= '0;
    end else begin
      err_vld <= (state_q == DONE);
      if (state_q == DONE) begin
        err_sat  <= avg_sum[11:1];
        prev_sat <= sat_now;
      end
    end
  end
`else
  // Output register: saturated result and its one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sat <= '0;
      err_vld <= 1'b0;
    end else begin
      err_vld <= (state_q == DONE);
      if (state_q == DONE)
        err_sat <= sat_now;
    end
  end
`endif

endmodule
